// File: rtl/mealy_nov_1011_pkg.sv
// Shared types and constants for the non-overlapping 1011 Mealy detector.
package mealy_nov_1011_pkg;

  // Two-bit state encoding; every encoding is a legal state.
  typedef enum logic [1:0] {
    S0   = 2'b00,  // idle, nothing useful seen
    S1   = 2'b01,  // "1" seen
    S10  = 2'b10,  // "10" seen
    S101 = 2'b11   // "101" seen
  } state_t;

  // Pattern being detected, MSB first on the serial input.
  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/mealy_nov_1011_if.sv
// Bundle between the state register (top) and the combinational
// next-state/output logic (sub-module).
//
// Handshake semantics: there is no valid/ready pair here. The top drives
// the current state and the sampled serial bit every cycle. The next-state
// block answers combinationally in the same cycle with next_state and the
// Mealy flag z. Nothing is held or stalled.
interface mealy_nov_1011_if;
  import mealy_nov_1011_pkg::*;

  state_t state;
  logic   x;
  state_t next_state;
  logic   z;

  modport master (output state, output x, input next_state, input z);
  modport slave  (input state, input x, output next_state, output z);

endinterface

// File: rtl/mealy_nov_1011_next.sv
// Pure combinational next-state and Mealy output logic for the 1011
// detector. Unknown state values fall back to S0 with z low.
module mealy_nov_1011_next
  import mealy_nov_1011_pkg::*;
(
  mealy_nov_1011_if.slave bus
);

  // Next-state decode; a completed match restarts at S0 so the final 1
  // is not reused.
  always_comb begin
    bus.next_state = S0;
    case (bus.state)
      S0:      bus.next_state = bus.x ? S1   : S0;
      S1:      bus.next_state = bus.x ? S1   : S10;
      S10:     bus.next_state = bus.x ? S101 : S0;
      S101:    bus.next_state = bus.x ? S0   : S10;
      default: bus.next_state = S0;
    endcase
  end

  // Mealy flag: high only while in S101 and the current bit is 1.
  always_comb begin
    bus.z = 1'b0;
    case (bus.state)
      S101:    bus.z = (bus.x == PATTERN[0]);
      default: bus.z = 1'b0;
    endcase
  end

endmodule

// File: rtl/mealy_nov_1011.sv
// Non-overlapping serial 1011 detector, Mealy style, MSB first.
// Optional simulation checks and a match counter are compiled in when
// MEALY_NOV_1011_ASSERT_EN is defined; port behaviour is identical either way.
module mealy_nov_1011
  import mealy_nov_1011_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic z
);

  state_t state;

  mealy_nov_1011_if fsm_if ();

  assign fsm_if.state = state;
  assign fsm_if.x     = x;

  mealy_nov_1011_next u_next (
    .bus (fsm_if.slave)
  );

  // State register; reset forces S0 immediately and drops any partial match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S0;
    else     state <= fsm_if.next_state;
  end

  // Output gated by reset so z stays low whatever x does during reset.
  always_comb begin
    z = fsm_if.z & ~rst;
  end

`ifdef MEALY_NOV_1011_ASSERT_EN
  logic [31:0] match_count;
  logic        z_q;

  // Count completed matches and remember the previous edge's flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= '0;
      z_q         <= 1'b0;
    end else begin
      if (z) match_count <= match_count + 32'd1;
      z_q <= z;
    end
  end

  a_no_double_z : assert property (@(posedge clk) disable iff (rst) !(z && z_q))
    else $error("z high on two consecutive edges");

  a_legal_state : assert property (@(posedge clk) disable iff (rst) !$isunknown(state))
    else $error("state outside legal encodings");
`endif

endmodule

// File: tb/tb_mealy_nov_1011.sv
// Directed bench for the non-overlapping 1011 Mealy detector.
module tb_mealy_nov_1011;
  import mealy_nov_1011_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mealy_nov_1011_if tb_if ();

  assign tb_if.state      = dut.state;
  assign tb_if.next_state = dut.fsm_if.next_state;

  mealy_nov_1011 dut (
    .clk (clk),
    .rst (rst),
    .x   (tb_if.x),
    .z   (tb_if.z)
  );

  // ---------------- scoreboard ----------------
  int   n_vec = 0;
  int   n_err = 0;
  int   z_hits = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    tb_if.x  = 1'b0;
    #1;
    check("reset_state", 32'(tb_if.state), 32'(S0));
    check("reset_z", 32'(tb_if.z), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one bit at the falling edge, check the Mealy flag before the
  // next rising edge against the head of the expected queue.
  task automatic apply_bit(input string tag, input logic b);
    logic [0:0] e;
    @(negedge clk);
    tb_if.x = b;
    #1;
    e = exp_q.pop_front();
    if (tb_if.z === 1'b1) z_hits++;
    check(tag, 32'(tb_if.z), 32'(e));
  endtask

  // bits[0] is the first bit sent; exp_z[i] is the flag expected on bit i.
  task automatic run_seq(input string tag, input int len,
                         input logic [15:0] bits, input logic [15:0] exp_z);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(exp_z[i]);
      apply_bit($sformatf("%s_b%0d", tag, i + 1), bits[i]);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    tb_if.x = 1'b0;

    // Long stream: matches at bits 5 and 15 only.
    do_reset();
    z_hits = 0;
    run_seq("long", 16, 16'b0110_1010_1101_1010, 16'b0100_0000_0001_0000);
    check("long_total", 32'(z_hits), 32'd2);

    // Non-overlap: the final 1 of a match does not seed a new one.
    do_reset();
    run_seq("novl", 7, 16'b0000_0000_0110_1101, 16'b0000_0000_0000_1000);

    // S101 with x=0 keeps the "10" suffix.
    do_reset();
    run_seq("sfx", 6, 16'b0000_0000_0011_0101, 16'b0000_0000_0010_0000);

    // S1 self-loop on repeated ones.
    do_reset();
    run_seq("ones", 6, 16'b0000_0000_0011_0111, 16'b0000_0000_0010_0000);

    // Asynchronous reset mid-sequence discards the partial "101".
    do_reset();
    run_seq("pre", 3, 16'b0000_0000_0000_0101, 16'b0000_0000_0000_0000);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_state", 32'(tb_if.state), 32'(S0));
    tb_if.x = 1'b1;
    #1;
    check("async_z", 32'(tb_if.z), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_next", 32'(tb_if.next_state), 32'(S1));
    exp_q.push_back(1'b0);
    apply_bit("rel_x1", 1'b1);
    @(posedge clk);
    #1;
    check("rel_state", 32'(tb_if.state), 32'(S1));
    run_seq("post", 4, 16'b0000_0000_0000_1101, 16'b0000_0000_0000_1000);

    // Held reset with toggling and unknown input.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tb_if.x = (i % 3 == 2) ? 1'bx : 1'(i % 2);
      #1;
      check($sformatf("hold_z%0d", i), 32'(tb_if.z), 32'd0);
      check($sformatf("hold_st%0d", i), 32'(tb_if.state), 32'(S0));
    end
`ifdef MEALY_NOV_1011_ASSERT_EN
    check("hold_count", dut.match_count, 32'd0);
`endif
    @(negedge clk);
    tb_if.x = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_seq("after", 4, 16'b0000_0000_0000_1101, 16'b0000_0000_0000_1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
